// File: rtl/frac_clk_channel.sv
// Single channel of the fractional clock-enable generator.
// A Bresenham phase accumulator produces a tick whenever acc + inc reaches
// the modulus; clk_out toggles on every tick. A new increment is staged
// by load and only applied on a tick edge, while the channel is disabled,
// or on a sync, so clk_out never emits a partial half-period.
//
// Reprogramming handshake: load is a single-cycle strobe with no ready.
// Every strobe is accepted, and the most recent value wins. pending stays
// high from the load edge until the edge on which that value becomes the
// active increment.
module frac_clk_channel #(
  parameter int INC_W     = 10,
  parameter int MOD       = 1000,
  parameter int INC_RESET = 1,
  parameter int SUM_W     = INC_W + 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [INC_W-1:0] inc,
  output logic             tick,
  output logic             clk_out,
  output logic             pending
);

  localparam logic [SUM_W-1:0] MOD_S     = SUM_W'(MOD);
  localparam logic [INC_W-1:0] MOD_V     = INC_W'(MOD);
  localparam logic [INC_W-1:0] INC_RST_V = (INC_RESET > MOD) ? MOD_V : INC_W'(INC_RESET);

  // Increments above the modulus would tick more than once per cycle,
  // which a single-pulse output cannot represent; saturate them.
  function automatic logic [INC_W-1:0] clamp_inc(input logic [INC_W-1:0] v);
    return (v > MOD_V) ? MOD_V : v;
  endfunction

  logic [INC_W-1:0] r_acc;
  logic [INC_W-1:0] r_inc_active;
  logic [INC_W-1:0] r_staged;
  logic             r_pending;
  logic             r_tick;
  logic             r_clk;

  logic [SUM_W-1:0] w_sum;
  logic [INC_W-1:0] w_acc_wrap;
  logic             w_wrap;
  logic             w_tick_now;
  logic             w_apply;

  // The sum is one bit wider than acc, so acc + inc never overflows.
  // The wrapped remainder is below MOD, so the low INC_W bits of the
  // difference are exact.
  assign w_sum      = SUM_W'(r_acc) + SUM_W'(r_inc_active);
  assign w_wrap     = (w_sum >= MOD_S);
  assign w_acc_wrap = w_sum[INC_W-1:0] - MOD_V;
  assign w_tick_now = en & w_wrap;
  assign w_apply    = r_pending & (w_tick_now | ~en);

  // Phase accumulator, tick pulse and square-wave output.
  always_ff @(posedge clk_in) begin
    if (rst || sync) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
      r_clk  <= 1'b0;
    end else if (en) begin
      if (w_wrap) begin
        r_acc  <= w_acc_wrap;
        r_tick <= 1'b1;
        r_clk  <= ~r_clk;
      end else begin
        r_acc  <= w_sum[INC_W-1:0];
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  // Increment staging and glitch-free application; a load in the same
  // edge as an application is staged afterwards and keeps pending set.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_inc_active <= INC_RST_V;
      r_staged     <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (sync) begin
        if (r_pending) begin
          r_inc_active <= clamp_inc(r_staged);
        end
        r_pending <= 1'b0;
      end else if (w_apply) begin
        r_inc_active <= clamp_inc(r_staged);
        r_pending    <= 1'b0;
      end
      if (load) begin
        r_staged  <= inc;
        r_pending <= 1'b1;
      end
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk;
  assign pending = r_pending;

endmodule

// File: rtl/frac_clk_divider.sv
// Multi-channel runtime-programmable fractional clock-enable generator.
// Each channel ticks at f_clk_in * inc / MOD and its clk_out runs at half
// the tick rate. sync_i restarts every channel phase-aligned.
module frac_clk_divider #(
  parameter int CHANNELS  = 2,
  parameter int INC_W     = 10,
  parameter int MOD       = 1000,
  parameter int INC_RESET = 1
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*INC_W-1:0] inc_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic                      sync_i,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       pending_o
);

  localparam int SUM_W = INC_W + 1;

  // One independent channel per slice of the packed increment bus.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    frac_clk_channel #(
      .INC_W     (INC_W),
      .MOD       (MOD),
      .INC_RESET (INC_RESET),
      .SUM_W     (SUM_W)
    ) u_channel (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[c]),
      .sync    (sync_i),
      .load    (load_i[c]),
      .inc     (inc_i[c*INC_W +: INC_W]),
      .tick    (tick_o[c]),
      .clk_out (clk_out[c]),
      .pending (pending_o[c])
    );
  end

endmodule

// File: tb/tb_frac_clk_divider.sv
// Bench for frac_clk_divider with MOD=10, INC_W=4, two channels.
// The reference model tracks each channel's unbounded phase total; a tick
// is any edge whose increment carries the total across a multiple of MOD.
module tb_frac_clk_divider;

  localparam int CH    = 2;
  localparam int IW    = 4;
  localparam int MODV  = 10;
  localparam int INC_R = 1;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic [CH-1:0]    en     = '0;
  logic [CH*IW-1:0] inc_i  = '0;
  logic [CH-1:0]    load_i = '0;
  logic             sync_i = 1'b0;
  logic [CH-1:0]    tick_o;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    pending_o;

  int checks = 0;
  int errors = 0;

  longint m_total [CH];
  int     m_inc   [CH];
  int     m_staged[CH];
  bit     m_pend  [CH];
  bit     m_tick  [CH];
  bit     m_clk   [CH];

  frac_clk_divider #(
    .CHANNELS  (CH),
    .INC_W     (IW),
    .MOD       (MODV),
    .INC_RESET (INC_R)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .inc_i     (inc_i),
    .load_i    (load_i),
    .sync_i    (sync_i),
    .tick_o    (tick_o),
    .clk_out   (clk_out),
    .pending_o (pending_o)
  );

  // Clock and watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic int clamp(input int v);
    return (v > MODV) ? MODV : v;
  endfunction

  // Behavioural reference: one call per rising edge, using the inputs
  // present at that edge.
  function automatic void model_update();
    bit crossed;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_total[c] = 0; m_inc[c] = clamp(INC_R); m_staged[c] = 0;
        m_pend[c] = 0;  m_tick[c] = 0;           m_clk[c] = 0;
      end else if (sync_i) begin
        m_total[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
        if (m_pend[c]) m_inc[c] = clamp(m_staged[c]);
        m_pend[c] = 0;
        if (load_i[c]) begin m_staged[c] = int'(inc_i[c*IW +: IW]); m_pend[c] = 1; end
      end else begin
        if (en[c]) begin
          crossed = ((m_total[c] + m_inc[c]) / MODV) != (m_total[c] / MODV);
          m_total[c] += m_inc[c];
          m_tick[c] = crossed;
          if (crossed) m_clk[c] = ~m_clk[c];
        end else begin
          m_tick[c] = 0;
        end
        if (m_pend[c] && (m_tick[c] || !en[c])) begin
          m_inc[c] = clamp(m_staged[c]);
          m_pend[c] = 0;
        end
        if (load_i[c]) begin m_staged[c] = int'(inc_i[c*IW +: IW]); m_pend[c] = 1; end
      end
    end
  endfunction

  // Driver tasks
  task automatic tick_clock();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic program_inc(input int ch, input int val);
    load_i[ch] = 1'b1;
    inc_i[ch*IW +: IW] = IW'(val);
    tick_clock();
    load_i = '0;
  endtask

  task automatic do_sync();
    sync_i = 1'b1;
    tick_clock();
    sync_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; load_i = '0; sync_i = 1'b0;
    repeat (2) tick_clock();
    load_i = 2'b11; inc_i = 8'h55; sync_i = 1'b1;
    tick_clock();
    load_i = '0; sync_i = 1'b0;
    checks++; if (tick_o !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b expected 00", tick_o); end
    checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk: got %b expected 00", clk_out); end
    checks++; if (pending_o !== 2'b00) begin errors++; $display("FAIL reset_pending: got %b expected 00", pending_o); end
    rst = 1'b0; en = 2'b01;
    for (int n = 1; n <= 10; n++) begin
      tick_clock();
      checks++;
      if (tick_o[0] !== (n == 10)) begin
        errors++; $display("FAIL reset_inc_tick edge %0d: got %b expected %b", n, tick_o[0], (n == 10));
      end
    end
  endtask

  task automatic test_basic_ratio();
    int cnt = 0;
    en = '0;
    program_inc(0, 3);
    en = 2'b01;
    do_sync();
    for (int n = 1; n <= 20; n++) begin
      bit exp_t;
      tick_clock();
      exp_t = (n == 4) || (n == 7) || (n == 10) || (n == 14) || (n == 17) || (n == 20);
      if (exp_t) cnt++;
      checks++;
      if (tick_o[0] !== exp_t) begin
        errors++; $display("FAIL ratio_tick edge %0d: got %b expected %b", n, tick_o[0], exp_t);
      end
      checks++;
      if (clk_out[0] !== cnt[0]) begin
        errors++; $display("FAIL ratio_clk edge %0d: got %b expected %b", n, clk_out[0], cnt[0]);
      end
    end
  endtask

  task automatic test_zero_and_clamp();
    en = '0;
    program_inc(0, 0);
    en = 2'b01;
    do_sync();
    for (int n = 1; n <= 100; n++) begin
      tick_clock();
      checks++;
      if (tick_o[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
        errors++; $display("FAIL zero_inc edge %0d: got tick %b clk %b expected 0 0", n, tick_o[0], clk_out[0]);
      end
    end
    program_inc(0, 15);
    repeat (3) tick_clock();
    checks++;
    if (pending_o[0] !== 1'b1) begin
      errors++; $display("FAIL clamp_pending: got %b expected 1", pending_o[0]);
    end
    do_sync();
    for (int n = 1; n <= 20; n++) begin
      tick_clock();
      checks++;
      if (tick_o[0] !== 1'b1 || clk_out[0] !== n[0]) begin
        errors++; $display("FAIL clamp_run edge %0d: got tick %b clk %b expected 1 %b", n, tick_o[0], clk_out[0], n[0]);
      end
    end
  endtask

  task automatic test_reprogram();
    int toggles[$];
    bit prev;
    en = '0;
    program_inc(0, 1);
    en = 2'b01;
    do_sync();
    prev = clk_out[0];
    for (int n = 1; n <= 40; n++) begin
      if (n == 13) begin load_i[0] = 1'b1; inc_i[IW-1:0] = 4'd5; end
      tick_clock();
      load_i = '0;
      checks++;
      if (pending_o[0] !== (n >= 13 && n < 20)) begin
        errors++; $display("FAIL reprog_pending edge %0d: got %b expected %b", n, pending_o[0], (n >= 13 && n < 20));
      end
      if (clk_out[0] !== prev) toggles.push_back(n);
      prev = clk_out[0];
    end
    checks++;
    if (toggles.size() != 12) begin
      errors++; $display("FAIL reprog_toggle_count: got %0d expected 12", toggles.size());
    end
    for (int i = 0; i < toggles.size(); i++) begin
      int run_len;
      int exp_len;
      run_len = (i == 0) ? toggles[0] : toggles[i] - toggles[i-1];
      exp_len = (i < 2) ? 10 : 2;
      checks++;
      if (run_len != exp_len) begin
        errors++; $display("FAIL reprog_run %0d: got %0d expected %0d", i, run_len, exp_len);
      end
    end
  endtask

  task automatic test_sync();
    logic [1:0] exp_v;
    en = '0;
    program_inc(0, 3);
    program_inc(1, 7);
    en = 2'b11;
    do_sync();
    repeat (7) tick_clock();
    do_sync();
    checks++;
    if (clk_out !== 2'b00 || tick_o !== 2'b00) begin
      errors++; $display("FAIL sync_clear: got clk %b tick %b expected 00 00", clk_out, tick_o);
    end
    for (int n = 1; n <= 4; n++) begin
      tick_clock();
      exp_v = (n == 2 || n == 3) ? 2'b10 : (n == 4) ? 2'b01 : 2'b00;
      checks++;
      if (tick_o !== exp_v) begin
        errors++; $display("FAIL sync_align edge %0d: got %b expected %b", n, tick_o, exp_v);
      end
    end
  endtask

  task automatic test_enable_and_reset();
    en = 2'b11;
    do_sync();
    repeat (5) tick_clock();
    en[0] = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (n == 1) begin load_i[0] = 1'b1; inc_i[IW-1:0] = 4'd1; end
      tick_clock();
      load_i = '0;
      checks++;
      if (tick_o[0] !== 1'b0 || clk_out[0] !== 1'b1 || pending_o[0] !== (n == 1)) begin
        errors++;
        $display("FAIL disable edge %0d: got tick %b clk %b pend %b expected 0 1 %b", n, tick_o[0], clk_out[0], pending_o[0], (n == 1));
      end
    end
    en[0] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick_clock();
      checks++;
      if (tick_o[0] !== (n == 5) || clk_out[0] !== (n < 5)) begin
        errors++; $display("FAIL reenable edge %0d: got tick %b clk %b expected %b %b", n, tick_o[0], clk_out[0], (n == 5), (n < 5));
      end
    end
    rst = 1'b1; load_i = 2'b11; sync_i = 1'b1;
    tick_clock();
    rst = 1'b0; load_i = '0; sync_i = 1'b0;
    checks++;
    if (tick_o !== 2'b00 || clk_out !== 2'b00 || pending_o !== 2'b00) begin
      errors++; $display("FAIL midrun_reset: got %b %b %b expected 00 00 00", tick_o, clk_out, pending_o);
    end
    en = 2'b01;
    for (int n = 1; n <= 10; n++) begin
      tick_clock();
      checks++;
      if (tick_o[0] !== (n == 10)) begin
        errors++; $display("FAIL post_reset_inc edge %0d: got %b expected %b", n, tick_o[0], (n == 10));
      end
    end
  endtask

  task automatic test_load_on_tick();
    en = '0;
    program_inc(0, 2);
    en = 2'b01;
    do_sync();
    for (int n = 1; n <= 16; n++) begin
      bit exp_t;
      bit exp_p;
      if (n == 2) begin load_i[0] = 1'b1; inc_i[IW-1:0] = 4'd4; end
      if (n == 5) begin load_i[0] = 1'b1; inc_i[IW-1:0] = 4'd1; end
      tick_clock();
      load_i = '0;
      exp_t = (n == 5) || (n == 8) || (n == 16);
      exp_p = (n >= 2) && (n <= 7);
      checks++;
      if (tick_o[0] !== exp_t || pending_o[0] !== exp_p) begin
        errors++; $display("FAIL load_on_tick edge %0d: got tick %b pend %b expected %b %b", n, tick_o[0], pending_o[0], exp_t, exp_p);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] e_t, e_c, e_p;
    for (int n = 0; n < 3000; n++) begin
      en     = 2'($urandom_range(0, 3));
      inc_i  = 8'($urandom);
      load_i = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      sync_i = ($urandom_range(0, 99) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      tick_clock();
      e_t = {m_tick[1], m_tick[0]};
      e_c = {m_clk[1], m_clk[0]};
      e_p = {m_pend[1], m_pend[0]};
      checks++;
      if (tick_o !== e_t || clk_out !== e_c || pending_o !== e_p) begin
        errors++;
        $display("FAIL random cycle %0d: got tick %b clk %b pend %b expected %b %b %b", n, tick_o, clk_out, pending_o, e_t, e_c, e_p);
      end
    end
    rst = 1'b0; sync_i = 1'b0; load_i = '0;
  endtask

  initial begin
    test_reset();
    test_basic_ratio();
    test_zero_and_clamp();
    test_reprogram();
    test_sync();
    test_enable_and_reset();
    test_load_on_tick();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
